// File: rtl/valu_seq.sv
// Packed-lane signed vector ALU: wrap/saturating add/sub, sequential dot product / MAC into a persistent accumulator.
// Latency: add/sub/pass result valid 1 cycle after accept; VDP/VMAC valid LANES+1 cycles after accept.
// Backpressure: result held stable in DONE until ready_i; no new request accepted until the result retires.
module valu_seq #(
    parameter  int LANES = 4,
    parameter  int EW    = 8,
    localparam int DW    = LANES * EW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic             sat_i,
    input  logic [DW-1:0]    v1_i,
    input  logic [DW-1:0]    v2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [DW-1:0]    v_o,
    output logic [LANES-1:0] over_o
);
    localparam int CW = $clog2(LANES);

    localparam logic [2:0] OP_VSUM = 3'b010;
    localparam logic [2:0] OP_VSUB = 3'b110;
    localparam logic [2:0] OP_VDP  = 3'b001;
    localparam logic [2:0] OP_VMAC = 3'b011;

    localparam logic [EW-1:0] LANE_MAX = {1'b0, {(EW-1){1'b1}}};
    localparam logic [EW-1:0] LANE_MIN = {1'b1, {(EW-1){1'b0}}};
    localparam logic [DW-1:0] ACC_MAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] ACC_MIN  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0]    v1_q, v2_q;
    logic             sat_q;
    logic [CW-1:0]    cnt_q;
    logic [DW-1:0]    acc_q;
    logic             acc_ovf_q;
    logic [DW-1:0]    v_q;
    logic [LANES-1:0] over_q;

    logic [DW-1:0]    lane_res;
    logic [LANES-1:0] lane_ovf;
    logic [EW-1:0]    la, lb, lr;
    logic             lo;

    logic signed [2*EW-1:0] ma, mb, prod;
    logic signed [DW-1:0]   prod_ext;
    logic [DW-1:0]          acc_sum, acc_next;
    logic                   mac_ovf, last_lane, is_mac;

    assign is_mac    = (op_i == OP_VDP) || (op_i == OP_VMAC);
    assign last_lane = (cnt_q == CW'(LANES - 1));

    // Per-lane add/sub straight from the request operands; the result is captured at accept.
    always_comb begin
        lane_res = '0;
        lane_ovf = '0;
        la = '0;
        lb = '0;
        lr = '0;
        lo = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            la = v1_i[k*EW +: EW];
            lb = v2_i[k*EW +: EW];
            if (op_i == OP_VSUB) begin
                lr = la - lb;
                lo = (la[EW-1] != lb[EW-1]) && (lr[EW-1] != la[EW-1]);
            end else begin
                lr = la + lb;
                lo = (la[EW-1] == lb[EW-1]) && (lr[EW-1] != la[EW-1]);
            end
            // On overflow the true result has v1's sign, so clamp toward it.
            if (lo && sat_i) begin
                lr = la[EW-1] ? LANE_MIN : LANE_MAX;
            end
            lane_res[k*EW +: EW] = lr;
            lane_ovf[k]          = lo;
        end
    end

    // One lane product per MUL cycle, sign-extended and accumulated with optional clamping.
    always_comb begin
        ma       = (2*EW)'($signed(v1_q[cnt_q*EW +: EW]));
        mb       = (2*EW)'($signed(v2_q[cnt_q*EW +: EW]));
        prod     = ma * mb;
        prod_ext = DW'(prod);
        acc_sum  = acc_q + prod_ext;
        mac_ovf  = (acc_q[DW-1] == prod_ext[DW-1]) && (acc_sum[DW-1] != acc_q[DW-1]);
        acc_next = acc_sum;
        if (mac_ovf && sat_q) begin
            acc_next = acc_q[DW-1] ? ACC_MIN : ACC_MAX;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    state_d = is_mac ? MUL : DONE;
                end
            end
            MUL: begin
                if (last_lane) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: operand capture, accumulator, held result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q      <= '0;
            v2_q      <= '0;
            sat_q     <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
            v_q       <= '0;
            over_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        v1_q  <= v1_i;
                        v2_q  <= v2_i;
                        sat_q <= sat_i;
                        cnt_q <= '0;
                        case (op_i)
                            OP_VSUM, OP_VSUB: begin
                                v_q    <= lane_res;
                                over_q <= lane_ovf;
                            end
                            OP_VDP: begin
                                acc_q     <= '0;
                                acc_ovf_q <= 1'b0;
                            end
                            OP_VMAC: ;
                            default: begin
                                v_q    <= v1_i;
                                over_q <= '0;
                            end
                        endcase
                    end
                end
                MUL: begin
                    acc_q     <= acc_next;
                    acc_ovf_q <= acc_ovf_q | mac_ovf;
                    cnt_q     <= cnt_q + 1'b1;
                    if (last_lane) begin
                        v_q    <= acc_next;
                        over_q <= {{(LANES-1){1'b0}}, acc_ovf_q | mac_ovf};
                    end
                end
                default: ;
            endcase
        end
    end

    assign v_o    = v_q;
    assign over_o = over_q;
endmodule
